tcp_mem_write_arbiter: RTL
==========================

// Module: tcp_mem_write_arbiter
// PURPOSE
// Shares one memory write port (cmd/data/status) among N_CH TCP channel write ports of the network stack.
// - Round-robin arbitration of write commands.
// - Data bursts are routed in command-grant order; write statuses are returned to the issuing channel in order.
// - Sits between the network stack write cmd/data/sts streams and a single datamover/memory controller port.
// PARAMETERS
// N_CH       2    number of requesting channels (>=2)
// ADDR_W     64   command address width
// LEN_W      32   command length width (bytes)
// DATA_W     512  data beat width
// STS_W      8    status word width
// ORD_DEPTH  16   entries per order FIFO (power of 2); max outstanding commands
// PORTS
// aclk              in   1              clock
// aresetn           in   1              sync active-low reset
// s_cmd_valid       in   N_CH           per-channel cmd valid
// s_cmd_ready       out  N_CH           per-channel cmd ready
// s_cmd_addr        in   N_CH*ADDR_W    per-channel address, ch i at [i*ADDR_W +: ADDR_W]
// s_cmd_len         in   N_CH*LEN_W     per-channel length
// m_cmd_valid/ready out/in 1            merged cmd handshake
// m_cmd_addr        out  ADDR_W         merged address
// m_cmd_len         out  LEN_W          merged length
// s_data_valid/ready/last in/out/in N_CH per-channel data handshake, end of burst
// s_data_data       in   N_CH*DATA_W    per-channel data
// s_data_keep       in   N_CH*DATA_W/8  per-channel byte enables
// m_data_valid/ready/last out/in/out 1  merged data handshake, end of burst
// m_data_data       out  DATA_W         merged data
// m_data_keep       out  DATA_W/8       merged byte enables
// s_sts_valid/ready in/out 1            memory status handshake
// s_sts_data        in   STS_W          memory status word
// m_sts_valid/ready out/in N_CH         per-channel status handshake
// m_sts_data        out  N_CH*STS_W     status word, replicated to all lanes
// stat_cmd_cnt      out  N_CH*32        per-channel accepted cmds (see CONFIGURATION)
// stat_burst_cnt    out  N_CH*32        per-channel completed bursts
// stat_sts_cnt      out  N_CH*32        per-channel returned statuses
// BEHAVIOUR
// Reset: all valid/ready outputs 0, m_cmd_* regs 0, rr pointer 0, both FIFOs empty, stats 0.
//   Mid-burst reset flushes everything; no resume.
// Cmd path: one output register, latency 1 cycle.
// - Accept when (!m_cmd_valid | m_cmd_ready) & !dfifo_full & !sfifo_full.
// - Round-robin grant: search starts at rr_ptr; after grant to ch g, rr_ptr <= (g+1)%N_CH.
// - s_cmd_ready[i]=1 only for the granted channel, only when accept is possible; at most one per cycle.
// - On accept: load m_cmd_addr/len; m_cmd_valid<=1; push g into sfifo.
//   Push g into dfifo only if len!=0; len==0 cmds expect no data but do return a status.
// - m_cmd_valid held with stable addr/len until m_cmd_ready.
// Order FIFOs: ORD_DEPTH deep, clog2(N_CH)-bit entries, occupancy counters.
// - Full blocks push even if a pop occurs the same cycle.
// - Simultaneous push/pop on non-full: count unchanged; pointers wrap mod ORD_DEPTH.
// Data path: combinational, zero latency, head h = dfifo head.
// - m_data_* = s_data_*[h]; m_data_valid = !dfifo_empty & s_data_valid[h].
// - s_data_ready[h] = !dfifo_empty & m_data_ready; other lanes ready=0.
// - Pop dfifo on accepted beat with last=1; next beat may come from a new channel the following cycle.
// - dfifo empty: all s_data_ready=0, m_data_valid=0; no data passes ahead of its command.
// Status path: combinational, head k = sfifo head.
// - m_sts_valid[k] = !sfifo_empty & s_sts_valid.
// - s_sts_ready = !sfifo_empty & m_sts_ready[k]; pop on handshake.
// - Status with sfifo empty is stalled (ready=0), never dropped.
// Data and status pops are independent; neither may block the other.
// CONFIGURATION
// Macro WR_ARB_STATS_EN:
// - defined: stat_* are 32-bit saturating counters per channel, incremented on cmd accept,
//   last-beat accept and status handshake respectively.
// - undefined: counter logic omitted; stat_* ports present and tied to 0.
// TESTING
// 1. Reset: aresetn=0 3 cycles -> all valid/ready 0; 1st cmd ch0 addr=0x1000 len=64 -> m_cmd_valid next cycle, addr 0x1000.
// 2. All N_CH=2 channels always valid, m_cmd_ready=1 -> grants alternate 0,1,0,1; 100 cmds = 50 per channel.
// 3. ch1 cmd then ch0 cmd; ch0 data ready first -> m_data_valid=0 until ch1 4-beat burst completes, then ch0 beats pass.
// 4. 16 cmds, no status returned -> 17th cmd gets s_cmd_ready=0; one status pop -> accepted next cycle.
// 5. Cmd len=0 on ch0, then len=128 on ch1 -> no ch0 data expected; statuses 0x80,0x81 reach ch0 then ch1.
// 6. Reset mid-burst (beat 2 of 4) -> FIFOs empty, stats 0 with WR_ARB_STATS_EN; new traffic routes correctly.

Source files
------------

// File: rtl/tcp_mem_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// tcp_mem_write_arbiter_if
// Bundles every stream of the write arbiter: the N_CH channel-side command,
// data and status streams (lanes packed channel-major, ch i at [i*W +: W]),
// the single memory-side command/data/status port, and the per-channel
// statistics outputs.
//   slave  : arbiter view (consumes s_cmd/s_data/s_sts, drives m_* and stats)
//   master : environment view (drives s_cmd/s_data/s_sts and the m_* readies)
// ---------------------------------------------------------------------------
interface tcp_mem_write_arbiter_if #(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 32,
  parameter int DATA_W = 512,
  parameter int STS_W  = 8
);
  logic [N_CH-1:0]            s_cmd_valid;
  logic [N_CH-1:0]            s_cmd_ready;
  logic [N_CH*ADDR_W-1:0]     s_cmd_addr;
  logic [N_CH*LEN_W-1:0]      s_cmd_len;
  logic                       m_cmd_valid;
  logic                       m_cmd_ready;
  logic [ADDR_W-1:0]          m_cmd_addr;
  logic [LEN_W-1:0]           m_cmd_len;

  logic [N_CH-1:0]            s_data_valid;
  logic [N_CH-1:0]            s_data_ready;
  logic [N_CH-1:0]            s_data_last;
  logic [N_CH*DATA_W-1:0]     s_data_data;
  logic [N_CH*DATA_W/8-1:0]   s_data_keep;
  logic                       m_data_valid;
  logic                       m_data_ready;
  logic                       m_data_last;
  logic [DATA_W-1:0]          m_data_data;
  logic [DATA_W/8-1:0]        m_data_keep;

  logic                       s_sts_valid;
  logic                       s_sts_ready;
  logic [STS_W-1:0]           s_sts_data;
  logic [N_CH-1:0]            m_sts_valid;
  logic [N_CH-1:0]            m_sts_ready;
  logic [N_CH*STS_W-1:0]      m_sts_data;

  logic [N_CH*32-1:0]         stat_cmd_cnt;
  logic [N_CH*32-1:0]         stat_burst_cnt;
  logic [N_CH*32-1:0]         stat_sts_cnt;

  modport slave (
    input  s_cmd_valid, s_cmd_addr, s_cmd_len, m_cmd_ready,
    input  s_data_valid, s_data_last, s_data_data, s_data_keep, m_data_ready,
    input  s_sts_valid, s_sts_data, m_sts_ready,
    output s_cmd_ready, m_cmd_valid, m_cmd_addr, m_cmd_len,
    output s_data_ready, m_data_valid, m_data_last, m_data_data, m_data_keep,
    output s_sts_ready, m_sts_valid, m_sts_data,
    output stat_cmd_cnt, stat_burst_cnt, stat_sts_cnt
  );

  modport master (
    output s_cmd_valid, s_cmd_addr, s_cmd_len, m_cmd_ready,
    output s_data_valid, s_data_last, s_data_data, s_data_keep, m_data_ready,
    output s_sts_valid, s_sts_data, m_sts_ready,
    input  s_cmd_ready, m_cmd_valid, m_cmd_addr, m_cmd_len,
    input  s_data_ready, m_data_valid, m_data_last, m_data_data, m_data_keep,
    input  s_sts_ready, m_sts_valid, m_sts_data,
    input  stat_cmd_cnt, stat_burst_cnt, stat_sts_cnt
  );
endinterface

// File: rtl/tcp_mem_write_arbiter.sv
// ---------------------------------------------------------------------------
// tcp_mem_write_arbiter
// Shares one memory write port among N_CH TCP channel write ports.
// Commands are granted round-robin into a single output register; the
// granted channel id is queued in an order FIFO for data (only for len!=0)
// and one for status, so bursts are routed and statuses returned in grant
// order. Data and status paths are combinational muxes steered by the FIFO
// heads.
// Ports:
//   aclk, aresetn  clock, synchronous active-low reset
//   bus            tcp_mem_write_arbiter_if.slave (cmd/data/sts streams, stats)
// Optional feature: define WR_ARB_STATS_EN to build the per-channel 32-bit
// saturating statistics counters; otherwise the stat_* outputs are 0.
// ---------------------------------------------------------------------------
module tcp_mem_write_arbiter #(
  parameter int N_CH      = 2,
  parameter int ADDR_W    = 64,
  parameter int LEN_W     = 32,
  parameter int DATA_W    = 512,
  parameter int STS_W     = 8,
  parameter int ORD_DEPTH = 16
) (
  input logic                    aclk,
  input logic                    aresetn,
  tcp_mem_write_arbiter_if.slave bus
);
  localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PTR_W  = $clog2(ORD_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int KEEP_W = DATA_W / 8;

  logic [IDX_W-1:0]  r_rr_ptr;
  logic              r_m_cmd_valid;
  logic [ADDR_W-1:0] r_m_cmd_addr;
  logic [LEN_W-1:0]  r_m_cmd_len;

  logic [IDX_W-1:0]  r_dfifo [ORD_DEPTH];
  logic [IDX_W-1:0]  r_sfifo [ORD_DEPTH];
  logic [PTR_W-1:0]  r_d_wr, r_d_rd, r_s_wr, r_s_rd;
  logic [CNT_W-1:0]  r_d_cnt, r_s_cnt;

  logic              w_d_empty, w_d_full, w_s_empty, w_s_full;
  logic              w_grant_vld;
  logic [IDX_W-1:0]  w_grant_idx;
  logic [ADDR_W-1:0] w_g_addr;
  logic [LEN_W-1:0]  w_g_len;
  logic              w_accept_ok, w_cmd_acc;
  logic              w_d_push, w_d_pop, w_s_push, w_s_pop;
  logic [IDX_W-1:0]  w_dhead, w_shead;

  assign w_d_empty = (r_d_cnt == '0);
  assign w_s_empty = (r_s_cnt == '0);
  assign w_d_full  = (r_d_cnt == CNT_W'(ORD_DEPTH));
  assign w_s_full  = (r_s_cnt == CNT_W'(ORD_DEPTH));

  // Round-robin search from r_rr_ptr: scanning offsets high-to-low lets the
  // smallest offset with a valid request win.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] jj;
    j           = 0;
    jj          = '0;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int off = N_CH - 1; off >= 0; off--) begin
      j = int'(r_rr_ptr) + off;
      if (j >= N_CH) j = j - N_CH;
      jj = IDX_W'(j);
      if (bus.s_cmd_valid[jj]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = jj;
      end
    end
  end

  assign w_g_addr    = bus.s_cmd_addr[int'(w_grant_idx)*ADDR_W +: ADDR_W];
  assign w_g_len     = bus.s_cmd_len[int'(w_grant_idx)*LEN_W +: LEN_W];
  // A full FIFO blocks the push even if it pops this cycle.
  assign w_accept_ok = (!r_m_cmd_valid | bus.m_cmd_ready) & !w_d_full & !w_s_full;
  assign w_cmd_acc   = w_accept_ok & w_grant_vld;
  assign w_s_push    = w_cmd_acc;
  assign w_d_push    = w_cmd_acc & (w_g_len != '0);

  assign bus.s_cmd_ready = w_cmd_acc ? (N_CH'(1) << w_grant_idx) : '0;
  assign bus.m_cmd_valid = r_m_cmd_valid;
  assign bus.m_cmd_addr  = r_m_cmd_addr;
  assign bus.m_cmd_len   = r_m_cmd_len;

  // ---- command output register stage ----
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_m_cmd_valid <= 1'b0;
      r_m_cmd_addr  <= '0;
      r_m_cmd_len   <= '0;
      r_rr_ptr      <= '0;
    end else if (w_cmd_acc) begin
      r_m_cmd_valid <= 1'b1;
      r_m_cmd_addr  <= w_g_addr;
      r_m_cmd_len   <= w_g_len;
      r_rr_ptr      <= (w_grant_idx == IDX_W'(N_CH - 1)) ? '0 : w_grant_idx + IDX_W'(1);
    end else if (bus.m_cmd_ready) begin
      r_m_cmd_valid <= 1'b0;
    end
  end

  // ---- order FIFOs (grant order for data and status) ----
  always_ff @(posedge aclk) begin
    if (w_d_push) r_dfifo[r_d_wr] <= w_grant_idx;
    if (w_s_push) r_sfifo[r_s_wr] <= w_grant_idx;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_d_wr  <= '0;
      r_d_rd  <= '0;
      r_d_cnt <= '0;
      r_s_wr  <= '0;
      r_s_rd  <= '0;
      r_s_cnt <= '0;
    end else begin
      if (w_d_push) r_d_wr <= r_d_wr + PTR_W'(1);
      if (w_d_pop)  r_d_rd <= r_d_rd + PTR_W'(1);
      if (w_d_push && !w_d_pop)      r_d_cnt <= r_d_cnt + CNT_W'(1);
      else if (!w_d_push && w_d_pop) r_d_cnt <= r_d_cnt - CNT_W'(1);
      if (w_s_push) r_s_wr <= r_s_wr + PTR_W'(1);
      if (w_s_pop)  r_s_rd <= r_s_rd + PTR_W'(1);
      if (w_s_push && !w_s_pop)      r_s_cnt <= r_s_cnt + CNT_W'(1);
      else if (!w_s_push && w_s_pop) r_s_cnt <= r_s_cnt - CNT_W'(1);
    end
  end

  // ---- data path: combinational mux on the data-order head ----
  assign w_dhead          = r_dfifo[r_d_rd];
  assign bus.m_data_valid = !w_d_empty & bus.s_data_valid[w_dhead];
  assign bus.m_data_last  = bus.s_data_last[w_dhead];
  assign bus.m_data_data  = bus.s_data_data[int'(w_dhead)*DATA_W +: DATA_W];
  assign bus.m_data_keep  = bus.s_data_keep[int'(w_dhead)*KEEP_W +: KEEP_W];
  assign bus.s_data_ready = (!w_d_empty && bus.m_data_ready) ? (N_CH'(1) << w_dhead) : '0;
  assign w_d_pop          = bus.m_data_valid & bus.m_data_ready & bus.m_data_last;

  // ---- status path: combinational demux on the status-order head ----
  assign w_shead         = r_sfifo[r_s_rd];
  assign bus.m_sts_valid = (!w_s_empty && bus.s_sts_valid) ? (N_CH'(1) << w_shead) : '0;
  assign bus.s_sts_ready = !w_s_empty & bus.m_sts_ready[w_shead];
  assign bus.m_sts_data  = {N_CH{bus.s_sts_data}};
  assign w_s_pop         = bus.s_sts_valid & bus.s_sts_ready;

`ifdef WR_ARB_STATS_EN
  logic [31:0] r_stat_cmd   [N_CH];
  logic [31:0] r_stat_burst [N_CH];
  logic [31:0] r_stat_sts   [N_CH];

  // ---- statistics counters (saturate at all-ones) ----
  always_ff @(posedge aclk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (!aresetn) begin
        r_stat_cmd[i]   <= '0;
        r_stat_burst[i] <= '0;
        r_stat_sts[i]   <= '0;
      end else begin
        if (w_cmd_acc && w_grant_idx == IDX_W'(i) && r_stat_cmd[i] != '1)
          r_stat_cmd[i] <= r_stat_cmd[i] + 32'd1;
        if (w_d_pop && w_dhead == IDX_W'(i) && r_stat_burst[i] != '1)
          r_stat_burst[i] <= r_stat_burst[i] + 32'd1;
        if (w_s_pop && w_shead == IDX_W'(i) && r_stat_sts[i] != '1)
          r_stat_sts[i] <= r_stat_sts[i] + 32'd1;
      end
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_stat
    assign bus.stat_cmd_cnt[gi*32 +: 32]   = r_stat_cmd[gi];
    assign bus.stat_burst_cnt[gi*32 +: 32] = r_stat_burst[gi];
    assign bus.stat_sts_cnt[gi*32 +: 32]   = r_stat_sts[gi];
  end
`else
  assign bus.stat_cmd_cnt   = '0;
  assign bus.stat_burst_cnt = '0;
  assign bus.stat_sts_cnt   = '0;
`endif

endmodule
